// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, functs, FSM states, select codes.
// JAL_JR_EN adds the jal/jr decode and the JR state.
package mips_ctrl_pkg;

    localparam int unsigned OP_WIDTH    = 6;
    localparam int unsigned STATE_WIDTH = 4;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FunctJr  = 6'b001000;
    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;

    typedef enum logic [2:0] {
        AluAnd = 3'b000,
        AluOr  = 3'b001,
        AluAdd = 3'b010,
        AluSub = 3'b110,
        AluSlt = 3'b111
    } alu_ctl_e;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10,
        AluOpOr    = 2'b11
    } alu_op_e;

    localparam logic [1:0] RegDstRt = 2'b00;
    localparam logic [1:0] RegDstRd = 2'b01;
    localparam logic [1:0] RegDstRa = 2'b10;

    localparam logic [1:0] MemToRegAlu  = 2'b00;
    localparam logic [1:0] MemToRegData = 2'b01;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAluResult = 2'b00;
    localparam logic [1:0] PcSrcAluOut    = 2'b01;
    localparam logic [1:0] PcSrcJump      = 2'b10;

    typedef enum logic [STATE_WIDTH-1:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StAluWb    = 4'd7,
        StAddiEx   = 4'd8,
        StAddiWb   = 4'd9,
        StBranch   = 4'd10,
`ifdef JAL_JR_EN
        StJump     = 4'd11,
        StJr       = 4'd12
`else
        StJump     = 4'd11
`endif
    } state_e;

    function automatic logic funct_is_alu(input logic [5:0] funct);
        return funct inside {FunctAdd, FunctSub, FunctAnd, FunctOr, FunctSlt};
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the control unit (master) and the datapath (slave).
interface multicycle_control_unit_if;

    logic [mips_ctrl_pkg::OP_WIDTH-1:0]    Op;
    logic [mips_ctrl_pkg::OP_WIDTH-1:0]    Funct;
    logic                                  Zero;
    logic                                  PC_En;
    logic                                  I_or_D;
    logic                                  Mem_Write;
    logic                                  IR_Write;
    logic [1:0]                            Reg_Dst;
    logic [1:0]                            Mem_to_Reg;
    logic                                  Reg_Write;
    logic                                  ALU_Src_A;
    logic [1:0]                            ALU_Src_B;
    logic [2:0]                            ALU_Control;
    logic [1:0]                            PC_Src;
    logic [mips_ctrl_pkg::STATE_WIDTH-1:0] State;

    modport master (
        input  Op, Funct, Zero,
        output PC_En, I_or_D, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write,
               ALU_Src_A, ALU_Src_B, ALU_Control, PC_Src, State
    );

    modport slave (
        output Op, Funct, Zero,
        input  PC_En, I_or_D, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write,
               ALU_Src_A, ALU_Src_B, ALU_Control, PC_Src, State
    );

endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp class and the instruction funct onto the ALU operation code.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_e    alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = AluAdd;
        unique case (alu_op_i)
            AluOpAdd: alu_control_o = AluAdd;
            AluOpSub: alu_control_o = AluSub;
            AluOpOr:  alu_control_o = AluOr;
            AluOpFunct: begin
                case (funct_i)
                    FunctAdd: alu_control_o = AluAdd;
                    FunctSub: alu_control_o = AluSub;
                    FunctAnd: alu_control_o = AluAnd;
                    FunctOr:  alu_control_o = AluOr;
                    FunctSlt: alu_control_o = AluSlt;
                    default:  alu_control_o = AluAdd;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multicycle MIPS core; drives every datapath strobe and mux select.
// Define JAL_JR_EN to add jal (link in DECODE) and jr (JR state).
module multicycle_control_unit
    import mips_ctrl_pkg::*;
(
    input logic                        clk,
    input logic                        reset,
    multicycle_control_unit_if.master  ctrl
);

    state_e     state_q, state_d;
    alu_op_e    alu_op;
    logic       alu_en;
    logic [2:0] alu_dec;
    logic       pc_en, mem_write, ir_write, reg_write;
    logic       is_alu_r;

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct_i       (ctrl.Funct),
        .alu_control_o (alu_dec)
    );

    assign is_alu_r = (ctrl.Op == OpRtype) && funct_is_alu(ctrl.Funct);

    always_ff @(posedge clk) begin
        if (reset) state_q <= StFetch;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d         = StFetch;
        alu_op          = AluOpAdd;
        alu_en          = 1'b0;
        pc_en           = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        reg_write       = 1'b0;
        ctrl.I_or_D     = 1'b0;
        ctrl.Reg_Dst    = RegDstRt;
        ctrl.Mem_to_Reg = MemToRegAlu;
        ctrl.ALU_Src_A  = 1'b0;
        ctrl.ALU_Src_B  = SrcBReg;
        ctrl.PC_Src     = PcSrcAluResult;
        case (state_q)
            StFetch: begin
                ir_write       = 1'b1;
                ctrl.ALU_Src_B = SrcBFour;
                alu_en         = 1'b1;
                pc_en          = 1'b1;
                state_d        = StDecode;
            end
            StDecode: begin
                // ALU_Out captures the branch target while the opcode is decoded
                ctrl.ALU_Src_B = SrcBImmSh;
                alu_en         = 1'b1;
                if (ctrl.Op == OpLw || ctrl.Op == OpSw) state_d = StMemAdr;
                else if (is_alu_r)                      state_d = StExecute;
                else if (ctrl.Op == OpAddi)             state_d = StAddiEx;
                else if (ctrl.Op == OpBeq || ctrl.Op == OpBne) state_d = StBranch;
                else if (ctrl.Op == OpJ)                state_d = StJump;
`ifdef JAL_JR_EN
                else if (ctrl.Op == OpJal) begin
                    // ALU_Out still holds PC+4 from FETCH: link it into r31
                    ctrl.Reg_Dst    = RegDstRa;
                    ctrl.Mem_to_Reg = MemToRegAlu;
                    reg_write       = 1'b1;
                    state_d         = StJump;
                end
                else if (ctrl.Op == OpRtype && ctrl.Funct == FunctJr) state_d = StJr;
`endif
            end
            StMemAdr: begin
                ctrl.ALU_Src_A = 1'b1;
                ctrl.ALU_Src_B = SrcBImm;
                alu_en         = 1'b1;
                state_d        = (ctrl.Op == OpSw) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                ctrl.I_or_D = 1'b1;
                state_d     = StMemWb;
            end
            StMemWb: begin
                ctrl.Mem_to_Reg = MemToRegData;
                reg_write       = 1'b1;
            end
            StMemWrite: begin
                ctrl.I_or_D = 1'b1;
                mem_write   = 1'b1;
            end
            StExecute: begin
                ctrl.ALU_Src_A = 1'b1;
                alu_op         = AluOpFunct;
                alu_en         = 1'b1;
                state_d        = StAluWb;
            end
            StAluWb: begin
                ctrl.Reg_Dst = RegDstRd;
                reg_write    = 1'b1;
            end
            StAddiEx: begin
                ctrl.ALU_Src_A = 1'b1;
                ctrl.ALU_Src_B = SrcBImm;
                alu_en         = 1'b1;
                state_d        = StAddiWb;
            end
            StAddiWb: reg_write = 1'b1;
            StBranch: begin
                ctrl.ALU_Src_A = 1'b1;
                alu_op         = AluOpSub;
                alu_en         = 1'b1;
                ctrl.PC_Src    = PcSrcAluOut;
                pc_en          = (ctrl.Op == OpBne) ? ~ctrl.Zero : ctrl.Zero;
            end
            StJump: begin
                ctrl.PC_Src = PcSrcJump;
                pc_en       = 1'b1;
            end
`ifdef JAL_JR_EN
            StJr: begin
                // rt is r0, so A | 0 passes the register value straight to the PC
                ctrl.ALU_Src_A = 1'b1;
                alu_op         = AluOpOr;
                alu_en         = 1'b1;
                pc_en          = 1'b1;
            end
`endif
            default: state_d = StFetch;
        endcase
    end

    assign ctrl.ALU_Control = alu_en ? alu_dec : 3'b000;
    assign ctrl.PC_En       = pc_en & ~reset;
    assign ctrl.IR_Write    = ir_write & ~reset;
    assign ctrl.Mem_Write   = mem_write & ~reset;
    assign ctrl.Reg_Write   = reg_write & ~reset;
    assign ctrl.State       = state_q;

endmodule
